// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pattern pipeline:
// 640x480@60 timing, channel colour constants and pattern mode encodings.
package vga_pkg;

   // 640x480@60 timing (pixel clock ~25.175 MHz)
   localparam int H_ACTIVE     = 640;
   localparam int H_SYNC_START = 656;
   localparam int H_SYNC_END   = 752;
   localparam int H_TOTAL      = 800;
   localparam int V_ACTIVE     = 480;
   localparam int V_SYNC_START = 490;
   localparam int V_SYNC_END   = 492;
   localparam int V_TOTAL      = 525;

   // Colour channel width shared by every stage driving the DAC pins
   localparam int c_COLOUR_BITS = 3;
   typedef logic [c_COLOUR_BITS-1:0] chan_t;

   typedef enum logic [1:0] {
      MODE_BLACK      = 2'd0,
      MODE_BARS       = 2'd1,
      MODE_CHECK      = 2'd2,
      MODE_BARS_NOBOX = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_NEG = 1'b0,
      DIR_POS = 1'b1
   } dir_e;

   function automatic chan_t col_black();
      return '0;
   endfunction

   function automatic chan_t col_white();
      return '1;
   endfunction

   // Mid-grey: only the channel MSB set
   function automatic chan_t col_grey();
      chan_t c;
      c = '0;
      c[c_COLOUR_BITS-1] = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: position/direction register with edge bounce.
// Arithmetic is one bit wider than the position so edge tests never wrap.
module vga_bounce_axis
   import vga_pkg::*;
#(
   parameter int W     = 10,
   parameter int LIMIT = 640,
   parameter int SIZE  = 32,
   parameter int STEP  = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         step_i,
   output logic [W-1:0] pos_o,
   output dir_e         dir_o
);

   logic [W-1:0] pos_q, pos_d;
   dir_e         dir_q, dir_d;
   logic [W:0]   pos_ext;

   // Next position/direction: advance one step, or clamp to the edge and reverse
   always_comb begin
      pos_d   = pos_q;
      dir_d   = dir_q;
      pos_ext = {1'b0, pos_q};
      if (step_i) begin
         if (dir_q == DIR_POS) begin
            if (pos_ext + (W+1)'(SIZE + STEP) > (W+1)'(LIMIT)) begin
               pos_d = W'(LIMIT - SIZE);
               dir_d = DIR_NEG;
            end else begin
               pos_d = pos_q + W'(STEP);
            end
         end else begin
            if (pos_ext < (W+1)'(STEP)) begin
               pos_d = '0;
               dir_d = DIR_POS;
            end else begin
               pos_d = pos_q - W'(STEP);
            end
         end
      end
   end

   // Position/direction state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pos_q <= '0;
         dir_q <= DIR_POS;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   assign pos_o = pos_q;
   assign dir_o = dir_q;

endmodule

// File: rtl/vga_bounce_box.sv
// Demo pattern stage in front of the VGA pins: background pattern plus a
// bouncing white square. Two register stages; syncs and DE ride alongside.
module vga_bounce_box
   import vga_pkg::*;
#(
   parameter int c_COUNTER_WIDTH = 10,
   parameter int c_HPIXELS       = H_ACTIVE,
   parameter int c_VPIXELS       = V_ACTIVE,
   parameter int c_BOX_SIZE      = 32,
   parameter int c_STEP          = 1,
   parameter bit c_VSYNC_POL     = 1'b0
) (
   input  logic                       SYS_CLK,
   input  logic                       SYS_RST,
   input  logic [c_COUNTER_WIDTH-1:0] i_x,
   input  logic [c_COUNTER_WIDTH-1:0] i_y,
   input  logic                       i_de,
   input  logic                       i_hsync,
   input  logic                       i_vsync,
   input  logic [1:0]                 i_mode,
   input  logic                       i_move_en,
   output chan_t                      VGA_R,
   output chan_t                      VGA_G,
   output chan_t                      VGA_B,
   output logic                       VGA_H,
   output logic                       VGA_V,
   output logic                       o_de
);

   localparam int W = c_COUNTER_WIDTH;
   localparam logic VS_ACTIVE   = c_VSYNC_POL;
   localparam logic VS_INACTIVE = ~c_VSYNC_POL;

   // Box state
   logic [W-1:0] box_x, box_y;
   dir_e         dir_x, dir_y;
   mode_e        mode_q;
   logic         frame_tick;

   // Stage 1
   logic         in_box_d, in_box_q;
   logic [2:0]   bar_d, bar_q;
   logic         chk_d, chk_q;
   mode_e        mode1_q;
   logic         de1_q, hs1_q, vs1_q;
   logic [W:0]   x_ext, y_ext, bx_ext, by_ext;

   // Stage 2
   chan_t        r_d, g_d, b_d;
   chan_t        r_q, g_q, b_q;
   logic         de2_q, hs2_q, vs2_q;

   // The stage-1 vsync register doubles as the edge detector's history
   assign frame_tick = (i_vsync == VS_ACTIVE) && (vs1_q == VS_INACTIVE);

   vga_bounce_axis #(
      .W     (W),
      .LIMIT (c_HPIXELS),
      .SIZE  (c_BOX_SIZE),
      .STEP  (c_STEP)
   ) u_axis_x (
      .clk_i  (SYS_CLK),
      .rst_i  (SYS_RST),
      .step_i (frame_tick && i_move_en),
      .pos_o  (box_x),
      .dir_o  (dir_x)
   );

   vga_bounce_axis #(
      .W     (W),
      .LIMIT (c_VPIXELS),
      .SIZE  (c_BOX_SIZE),
      .STEP  (c_STEP)
   ) u_axis_y (
      .clk_i  (SYS_CLK),
      .rst_i  (SYS_RST),
      .step_i (frame_tick && i_move_en),
      .pos_o  (box_y),
      .dir_o  (dir_y)
   );

   // Pattern mode only changes at frame boundaries
   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         mode_q <= MODE_BLACK;
      end else if (frame_tick) begin
         mode_q <= mode_e'(i_mode);
      end
   end

   // Stage 1 decode: box hit test, bar index from fixed column thresholds, checker bit
   always_comb begin
      x_ext    = {1'b0, i_x};
      y_ext    = {1'b0, i_y};
      bx_ext   = {1'b0, box_x};
      by_ext   = {1'b0, box_y};
      in_box_d = (x_ext >= bx_ext) && (x_ext < bx_ext + (W+1)'(c_BOX_SIZE)) &&
                 (y_ext >= by_ext) && (y_ext < by_ext + (W+1)'(c_BOX_SIZE));
      chk_d    = i_x[5] ^ i_y[5];
      bar_d    = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (x_ext >= (W+1)'(k * c_HPIXELS / 8)) begin
            bar_d = 3'(k);
         end
      end
   end

   // Stage 1 register: decoded pixel attributes plus delayed timing signals
   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         in_box_q <= 1'b0;
         bar_q    <= 3'd0;
         chk_q    <= 1'b0;
         mode1_q  <= MODE_BLACK;
         de1_q    <= 1'b0;
         hs1_q    <= 1'b1;
         vs1_q    <= VS_INACTIVE;
      end else begin
         in_box_q <= in_box_d;
         bar_q    <= bar_d;
         chk_q    <= chk_d;
         mode1_q  <= mode_q;
         de1_q    <= i_de;
         hs1_q    <= i_hsync;
         vs1_q    <= i_vsync;
      end
   end

   // Stage 2 colour mux: blanking, box overlay, then background pattern
   always_comb begin
      r_d = col_black();
      g_d = col_black();
      b_d = col_black();
      if (de1_q) begin
         if (in_box_q && (mode1_q != MODE_BARS_NOBOX)) begin
            r_d = col_white();
            g_d = col_white();
            b_d = col_white();
         end else begin
            case (mode1_q)
               MODE_BARS, MODE_BARS_NOBOX: begin
                  r_d = bar_q[2] ? col_white() : col_black();
                  g_d = bar_q[1] ? col_white() : col_black();
                  b_d = bar_q[0] ? col_white() : col_black();
               end
               MODE_CHECK: begin
                  r_d = chk_q ? col_grey() : col_black();
                  g_d = chk_q ? col_grey() : col_black();
                  b_d = chk_q ? col_grey() : col_black();
               end
               default: begin
                  r_d = col_black();
                  g_d = col_black();
                  b_d = col_black();
               end
            endcase
         end
      end
   end

   // Stage 2 register: output pins
   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         r_q   <= '0;
         g_q   <= '0;
         b_q   <= '0;
         de2_q <= 1'b0;
         hs2_q <= 1'b1;
         vs2_q <= VS_INACTIVE;
      end else begin
         r_q   <= r_d;
         g_q   <= g_d;
         b_q   <= b_d;
         de2_q <= de1_q;
         hs2_q <= hs1_q;
         vs2_q <= vs1_q;
      end
   end

   assign VGA_R = r_q;
   assign VGA_G = g_q;
   assign VGA_B = b_q;
   assign VGA_H = hs2_q;
   assign VGA_V = vs2_q;
   assign o_de  = de2_q;

endmodule

// File: doc/vga_bounce_box.md
Name: vga_bounce_box

Overview:
- Pixel-colour stage directly upstream of the VGA output pins; consumes the timing generator's pixel coordinates, data-enable and syncs.
- Produces registered RGB with syncs delay-matched to the colour pipeline.
- Renders a selectable background (black, colour bars, checkerboard) with a white square that moves once per frame and bounces off the screen edges.
- Used as the board bring-up and demo pattern source.

Parameters:
- c_COLOUR_BITS, 3, bits per colour channel.
- c_COUNTER_WIDTH, 10, width of x/y coordinates and box position registers.
- c_HPIXELS, 640, active pixels per line.
- c_VPIXELS, 480, active lines per frame.
- c_BOX_SIZE, 32, box edge length in pixels.
- c_STEP, 1, box displacement per frame on each axis.
- c_VSYNC_POL, 0, active level of i_vsync (0 = active-low).

Ports:
- SYS_CLK  in  1  pixel clock.
- SYS_RST  in  1  asynchronous, active-high reset.
- i_x  in  c_COUNTER_WIDTH  current pixel column from the timing generator.
- i_y  in  c_COUNTER_WIDTH  current pixel row.
- i_de  in  1  active-video flag.
- i_hsync  in  1  horizontal sync from the timing generator.
- i_vsync  in  1  vertical sync from the timing generator.
- i_mode  in  2  pattern select.
- i_move_en  in  1  when 1, box advances each frame.
- VGA_R, VGA_G, VGA_B  out  c_COLOUR_BITS each  pixel colour.
- VGA_H, VGA_V  out  1  delayed syncs.
- o_de  out  1  delayed active-video flag.

Behaviour:
Reset and clocking
- One clock, SYS_CLK. SYS_RST is asynchronous, active-high.
- Under reset: RGB=0, o_de=0, VGA_H=VGA_V=inactive level (VGA_V = ~c_VSYNC_POL; VGA_H = 1).
- Under reset: box_x=box_y=0, dir_x=dir_y=+, mode_q=0, all pipeline registers cleared.
- Asserting reset mid-frame clears everything immediately. The first frame tick after release moves the box from (0,0).

Latency
- Exactly 2 cycles from i_x/i_y/i_de/i_hsync/i_vsync to VGA_R/G/B, o_de, VGA_H, VGA_V.
- Syncs are passed through delay registers without inversion.

Frame tick
- Single-cycle pulse on the transition of i_vsync from inactive to active, as defined by c_VSYNC_POL.
- Edge detection uses a registered copy of i_vsync.

Box update (on frame tick only)
- Box updates only when i_move_en=1. Each axis is handled independently:
  - dir + and pos + c_BOX_SIZE + c_STEP > limit: pos = limit - c_BOX_SIZE, dir becomes -.
  - dir - and pos < c_STEP: pos = 0, dir becomes +.
  - otherwise: pos = pos ± c_STEP.
- limit is c_HPIXELS for x and c_VPIXELS for y.
- Arithmetic is one bit wider than c_COUNTER_WIDTH, so no wrap-around is possible.

Mode latch
- i_mode is sampled into mode_q on the frame tick regardless of i_move_en.
- Changing i_mode mid-frame never affects the current frame.

Stage 1 (registered)
- in_box = (box_x ≤ i_x < box_x + c_BOX_SIZE) && (box_y ≤ i_y < box_y + c_BOX_SIZE).
- bar = 3-bit index, computed by comparing i_x against k*c_HPIXELS/8 (k=1..7) elaboration-time constants. No divider.
- chk = i_x[5] ^ i_y[5].
- de, hsync and vsync are delayed alongside.
- Box position and mode_q are read as they stand in the cycle the pixel is sampled.

Stage 2 (registered) colour mux
- de=0: RGB = 0.
- in_box and mode_q≠3: RGB = all ones (white).
- Otherwise, by mode_q:
  - 0: black.
  - 1 or 3: colour bars. R = all ones if bar[2], G = all ones if bar[1], B = all ones if bar[0]. Bar 0 is black, bar 7 is white.
  - 2: checkerboard. chk=1 gives mid-grey (MSB only set on each channel); chk=0 gives black.

Simultaneous events
- A frame tick in the same cycle as an active pixel: that pixel sees the old box position and old mode; the next pixel sees the new ones.
- In practice i_de=0 during vsync.

Decomposition:
- Shared package vga_pkg holds:
  - 640x480@60 timing constants (656/752/800, 490/492/525);
  - colour constants (black, white, grey) as functions of c_COLOUR_BITS;
  - mode encodings MODE_BLACK=0, MODE_BARS=1, MODE_CHECK=2, MODE_BARS_NOBOX=3.
- One natural sub-module, vga_bounce_axis: the single-axis position/direction register plus bounce logic, parameterised by limit, size and step. It is instantiated twice, once for x and once for y.

Test Plan:
- Reset, mode 0, drive (x,y)=(10,10) with de=1 → white (7,7,7) on cycle+2. Drive (40,10) → (0,0,0). Drive de=0 at (10,10) → (0,0,0).
- Toggle i_hsync/i_vsync with a known pattern → VGA_H/VGA_V reproduce it exactly 2 cycles later. During reset: VGA_H=1, VGA_V=~c_VSYNC_POL.
- i_move_en=1, 1 frame tick → box_x=1, box_y=1. After 448 ticks → box_y=448, dir_y=+. Tick 449 → box_y=448, dir_y=-. Tick 450 → box_y=447.
- x bounce: tick 608 → box_x=608. Tick 609 → box_x=608, dir_x=-. Tick 610 → box_x=607. With i_move_en=0, 5 ticks → position unchanged.
- Mode 1 set mid-frame → no change until the next frame tick. After it, pixel (0,200) → black, (639,200) → white, (80,200) → (0,0,7) blue. Box area still white.
- Assert SYS_RST mid-frame with box at (300,200), dir_x=- → outputs and position clear asynchronously. After release and 1 tick → box at (1,1), dir +.
